// File: rtl/mips_bp_pkg.sv
// mips_bp_pkg: shared branch-type encoding and 2-bit counter helpers for the branch predictor
package mips_bp_pkg;
   typedef enum logic [1:0] {BR = 2'd0, JMP = 2'd1, CALL = 2'd2, RET = 2'd3} bp_type_t;
   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;
   function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
      return up ? (c == CTR_ST ? c : c + 2'd1) : (c == CTR_SNT ? c : c - 2'd1);
   endfunction
endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack; overflow overwrites the oldest entry, underflow wraps
module bp_ras #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   output logic [31:0] top
);
   localparam int PW = $clog2(DEPTH);
   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] top_ptr;
   always_comb top_ptr = ptr - PW'(1);
   always_comb top = mem[top_ptr];
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[ptr] <= push_data;
         ptr      <= ptr + PW'(1);
      end else if (pop) begin
         ptr <= top_ptr;
      end
   end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, IF lookup and EX training/mispredict.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor import mips_bp_pkg::*; #(
   parameter int ENTRIES   = 64,
   parameter int TAG_W     = 10,
   parameter int RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   input  logic        if_stall,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  bp_type_t    ex_type,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc
);
   localparam int IDX_W = $clog2(ENTRIES);
   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   bp_type_t           type_mem [ENTRIES];
   logic [1:0]         ctr_mem [ENTRIES];
   logic [29:0]        tgt_mem [ENTRIES];
   logic [IDX_W-1:0]   if_idx, ex_idx;
   logic [TAG_W-1:0]   if_tag, ex_tag;
   logic               ex_hit, wr_en;
   logic [1:0]         ctr_next;
   logic [31:0]        btb_target;
   logic               unused_ok;
   always_comb begin
      if_idx     = if_pc[IDX_W+1:2];
      if_tag     = if_pc[IDX_W+TAG_W+1:IDX_W+2];
      ex_idx     = ex_pc[IDX_W+1:2];
      ex_tag     = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
      pred_hit   = valid[if_idx] && tag_mem[if_idx] == if_tag;
      pred_taken = pred_hit && (type_mem[if_idx] != BR || ctr_mem[if_idx][1]);
      btb_target = {tgt_mem[if_idx], 2'b00};
      ex_hit     = valid[ex_idx] && tag_mem[ex_idx] == ex_tag;
      wr_en      = ex_valid && (ex_hit || ex_taken);
      ctr_next   = ex_hit ? ctr_step(ctr_mem[ex_idx], ex_taken) : CTR_WT;
      mispredict = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
      redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
   end
`ifdef BP_RAS_EN
   logic [31:0] ras_top;
   bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (pred_hit && type_mem[if_idx] == CALL && !if_stall),
      .pop       (pred_hit && type_mem[if_idx] == RET && !if_stall),
      .push_data (if_pc + 32'd4),
      .top       (ras_top)
   );
   always_comb pred_target = !pred_hit ? '0 : type_mem[if_idx] == RET ? ras_top : btb_target;
`else
   always_comb pred_target = pred_hit ? btb_target : '0;
`endif
   // address bits outside index/tag, and the stall when no RAS is built, are intentionally ignored
   assign unused_ok = ^{if_pc, ex_pc, if_stall, RAS_DEPTH[0]};
   always_ff @(posedge clk) begin
      if (rst) valid <= '0;
      else if (wr_en) valid[ex_idx] <= 1'b1;
   end
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[ex_idx]  <= ex_tag;
         type_mem[ex_idx] <= ex_type;
         ctr_mem[ex_idx]  <= ctr_next;
         tgt_mem[ex_idx]  <= ex_target[31:2];
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for branch_predictor (RAS checks when BP_RAS_EN is defined)
module tb_branch_predictor;
   import mips_bp_pkg::*;
   logic        clk = 0;
   logic        rst, if_stall, ex_valid, ex_taken, ex_pred_taken;
   logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
   bp_type_t    ex_type;
   logic        pred_hit, pred_taken, mispredict;
   logic [31:0] pred_target, redirect_pc;
   typedef struct {string name; logic [31:0] val;} exp_t;
   exp_t q[$];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   branch_predictor dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_stall(if_stall),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_type(ex_type), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc)
   );
   task automatic push_exp(string n, logic [31:0] v);
      q.push_back('{n, v});
   endtask
   task automatic exp_lookup(logic h, logic t, logic [31:0] tg);
      push_exp("pred_hit", {31'd0, h});
      push_exp("pred_taken", {31'd0, t});
      push_exp("pred_target", tg);
   endtask
   task automatic exp_ex(logic m, logic [31:0] r);
      push_exp("mispredict", {31'd0, m});
      push_exp("redirect_pc", r);
   endtask
   task automatic check(string n, logic [31:0] obs);
      exp_t e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $error("FAIL %s scoreboard empty observed=%h", n, obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.val && n == e.name)
            else begin
               bad++;
               $error("FAIL %s observed=%h expected=%h (%s)", n, obs, e.val, e.name);
            end
      end
   endtask
   task automatic drive_ex(logic v, logic [31:0] pc, bp_type_t t, logic tk, logic [31:0] tg,
                           logic ptk, logic [31:0] ptg);
      ex_valid = v; ex_pc = pc; ex_type = t; ex_taken = tk;
      ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
   endtask
   task automatic step(bit lk, bit ex);
      @(negedge clk);
      if (lk) begin
         check("pred_hit", {31'd0, pred_hit});
         check("pred_taken", {31'd0, pred_taken});
         check("pred_target", pred_target);
      end
      if (ex) begin
         check("mispredict", {31'd0, mispredict});
         check("redirect_pc", redirect_pc);
      end
      @(posedge clk); #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      logic [31:0] calls [5];
      logic [31:0] ret_exp [5];
      calls = '{32'h3020, 32'h3060, 32'h30a0, 32'h30c0, 32'h30e0};
      ret_exp = '{32'h30e4, 32'h30c4, 32'h30a4, 32'h3064, 32'h30e4};
      rst = 1; if_stall = 0; if_pc = 0;
      drive_ex(0, 0, BR, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 0;
      // reset state
      if_pc = 32'h3000; exp_lookup(0, 0, 0); exp_ex(0, 32'h4); step(1, 1);
      // allocation on taken miss; same-cycle lookup sees old contents
      drive_ex(1, 32'h3010, BR, 1, 32'h3040, 0, 0);
      if_pc = 32'h3010; exp_lookup(0, 0, 0); exp_ex(1, 32'h3040); step(1, 1);
      ex_valid = 0; exp_lookup(1, 1, 32'h3040); step(1, 0);
      // counter 2 -> 1 -> 0 -> 0
      drive_ex(1, 32'h3010, BR, 0, 32'h3040, 1, 32'h3040);
      exp_lookup(1, 1, 32'h3040); exp_ex(1, 32'h3014); step(1, 1);
      ex_valid = 0; exp_lookup(1, 0, 32'h3040); step(1, 0);
      for (int i = 0; i < 2; i++) begin
         drive_ex(1, 32'h3010, BR, 0, 32'h3040, 0, 32'h3040);
         exp_ex(0, 32'h3014); step(0, 1);
      end
      ex_valid = 0; exp_lookup(1, 0, 32'h3040); step(1, 0);
      // counter 0 -> 1 -> 2 -> 3 -> 3, then one not-taken leaves it taken
      for (int i = 0; i < 4; i++) begin
         drive_ex(1, 32'h3010, BR, 1, 32'h3040, 0, 32'h3040);
         exp_ex(1, 32'h3040); step(0, 1);
      end
      drive_ex(1, 32'h3010, BR, 0, 32'h3040, 1, 32'h3040);
      exp_ex(1, 32'h3014); step(0, 1);
      ex_valid = 0; exp_lookup(1, 1, 32'h3040); step(1, 0);
      // taken with wrong target vs correct target
      drive_ex(1, 32'h3010, BR, 1, 32'h3040, 1, 32'h3044); exp_ex(1, 32'h3040); step(0, 1);
      drive_ex(1, 32'h3010, BR, 1, 32'h3040, 1, 32'h3040); exp_ex(0, 32'h3040); step(0, 1);
      // aliasing eviction
      drive_ex(1, 32'h3110, BR, 1, 32'h3200, 0, 0); exp_ex(1, 32'h3200); step(0, 1);
      ex_valid = 0;
      if_pc = 32'h3010; exp_lookup(0, 0, 0); step(1, 0);
      if_pc = 32'h3110; exp_lookup(1, 1, 32'h3200); step(1, 0);
      // ex_valid low: no mispredict, no write
      drive_ex(0, 32'h3300, BR, 1, 32'h3400, 0, 0);
      if_pc = 32'h3300; exp_lookup(0, 0, 0); exp_ex(0, 32'h3400); step(1, 1);
      exp_lookup(0, 0, 0); step(1, 0);
      // unconditional jump predicts taken
      drive_ex(1, 32'h3050, JMP, 1, 32'h3400, 0, 0); exp_ex(1, 32'h3400); step(0, 1);
      ex_valid = 0; if_pc = 32'h3050; exp_lookup(1, 1, 32'h3400); step(1, 0);
`ifndef BP_RAS_EN
      drive_ex(1, 32'h3080, RET, 1, 32'h3024, 0, 0); exp_ex(1, 32'h3024); step(0, 1);
      ex_valid = 0; if_pc = 32'h3080; exp_lookup(1, 1, 32'h3024); step(1, 0);
`endif
      // reset mid-operation discards training
      rst = 1; if_pc = 32'h3110; exp_lookup(1, 1, 32'h3200); step(1, 0);
      rst = 0; exp_lookup(0, 0, 0); step(1, 0);
      if_pc = 32'h3050; exp_lookup(0, 0, 0); step(1, 0);
`ifdef BP_RAS_EN
      if_pc = 0;
      for (int i = 0; i < 5; i++) begin
         drive_ex(1, calls[i], CALL, 1, 32'h3500 + 32'(i * 16), 0, 0);
         exp_ex(1, 32'h3500 + 32'(i * 16)); step(0, 1);
      end
      drive_ex(1, 32'h3080, RET, 1, 32'h3024, 0, 0); exp_ex(1, 32'h3024); step(0, 1);
      ex_valid = 0;
      if_pc = 32'h3020; exp_lookup(1, 1, 32'h3500); step(1, 0);
      // stalled CALL hit pushes once
      if_pc = 32'h3060; if_stall = 1;
      for (int i = 0; i < 3; i++) begin exp_lookup(1, 1, 32'h3510); step(1, 0); end
      if_stall = 0; exp_lookup(1, 1, 32'h3510); step(1, 0);
      if_pc = 32'h3080; exp_lookup(1, 1, 32'h3064); step(1, 0);
      exp_lookup(1, 1, 32'h3024); step(1, 0);
      // five nested calls overflow the four-deep stack
      for (int i = 0; i < 5; i++) begin
         if_pc = calls[i]; exp_lookup(1, 1, 32'h3500 + 32'(i * 16)); step(1, 0);
      end
      if_pc = 32'h3080;
      for (int i = 0; i < 5; i++) begin exp_lookup(1, 1, ret_exp[i]); step(1, 0); end
      if_pc = 0;
      drive_ex(1, 32'h3080, RET, 1, 32'h3024, 1, 32'h30e4); exp_ex(1, 32'h3024); step(0, 1);
      ex_valid = 0;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline; replaces the fixed predict-not-taken / flush-in-EX scheme. It has a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, looked up combinationally in IF and trained from EX. It also reports mispredict plus the redirect PC to the hazard unit, which drives NPC select and the IF/ID and ID/EX flush.

## Interface
Parameters:
- ENTRIES, 64: BTB depth; power of two, ≥4; IDX_W = log2(ENTRIES)
- TAG_W, 10: stored tag width; IDX_W+TAG_W ≤ 30
- RAS_DEPTH, 4: return-address-stack depth; power of two; only used with BP_RAS_EN

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- if_pc  in  32  PC being fetched
- if_stall  in  1  IF held this cycle (PCWrite low); blocks RAS push/pop
- pred_hit  out  1  valid BTB entry, tag match
- pred_taken  out  1  predict redirect
- pred_target  out  32  predicted NPC when pred_taken
- ex_valid  in  1  EX holds a real (unflushed) branch/jump
- ex_pc  in  32  PC of that instruction
- ex_type  in  2  bp_type_t: BR, JMP, CALL, RET
- ex_taken  in  1  resolved direction (1 for all jumps)
- ex_target  in  32  resolved target
- ex_pred_taken  in  1  pred_taken carried down the pipeline
- ex_pred_target  in  32  pred_target carried down the pipeline
- mispredict  out  1  flush IF/ID, ID/EX; load redirect_pc
- redirect_pc  out  32  correct NPC

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag, type, 2-bit counter, target[31:2].
- Lookup (combinational):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (type≠BR | ctr[1]).
  - pred_target = stored target; for RET with BP_RAS_EN, the RAS top instead.
- Update on ex_valid at clock edge:
  - Hit on ex_pc: counter saturating ±1 (3 stays 3, 0 stays 0); target and type rewritten.
  - Miss: allocate only if ex_taken. Counter = 2'b10 (weakly taken), overwriting any prior occupant.
  - Miss, not taken: no write.
- mispredict = ex_valid & ((ex_taken≠ex_pred_taken) | (ex_taken & ex_target≠ex_pred_target)).
- redirect_pc = ex_taken ? ex_target : ex_pc+4.
- ex_valid low: mispredict = 0 and no table write.

## Timing
- Lookup and mispredict are zero latency (combinational). Table writes appear in the next cycle.
- Read-during-write at the same index: lookup returns the old contents.
- Reset: all valid bits cleared and RAS pointer = 0 in the cycle after rst is sampled high. Therefore pred_hit = pred_taken = 0, pred_target = 0, mispredict = 0 (absent ex_valid).
- Reset asserted mid-operation discards all training.
- Simultaneous mispredict and RAS activity: the RAS is not repaired on flush (accepted imprecision).

## Configuration
- BP_RAS_EN defined:
  - RAS of RAS_DEPTH entries.
  - Lookup hit of type CALL with !if_stall pushes if_pc+4.
  - Hit of type RET with !if_stall pops; pred_target = top before pop.
  - Overflow wraps and overwrites the oldest entry; underflow wraps and yields a stale value (caught as mispredict).
  - Push and pop in the same cycle is impossible (single lookup).
- Undefined: no RAS; RET entries predict the BTB-stored target like JMP.

## Structure
- Package mips_bp_pkg:
  - bp_type_t (BR=0, JMP=1, CALL=2, RET=3).
  - Counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
- Sub-module bp_ras: stack plus pointer; clk, rst, push, pop, push_data, top. Instantiated only under BP_RAS_EN.

## Test plan
- Reset, then if_pc=0x0000_3000 → pred_hit=0, pred_taken=0.
- BR at 0x0000_3010 taken to 0x0000_3040 (ex_pred_taken=0) → mispredict=1, redirect_pc=0x0000_3040. Next cycle lookup of 0x3010 → hit, taken, target 0x3040.
- Same BR resolved not-taken twice → ctr 2→1→0. Lookup → pred_taken=0. A third not-taken → ctr stays 0, mispredict=0.
- Aliasing: ENTRIES=64, BR at 0x3010 and 0x3110 (same index, different tag) → second allocation evicts the first; lookup of 0x3010 → pred_hit=0.
- BP_RAS_EN: CALL at 0x3020, later RET at 0x3080 → RET lookup pred_target=0x3024. Five nested CALLs with RAS_DEPTH=4 → the innermost four returns correct, the fifth mispredicts.
- if_stall=1 during a CALL hit for 3 cycles → exactly one push.
